instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams image bytes into instruction memory as
// little-endian words and holds the CPU in reset until a full image is in.
// Optional feature: define LOADER_CHECKSUM_EN to build a running sum of
// every written word; otherwise checksum is tied to zero.
module instr_mem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERROR} state_t;

  // word address carries one extra bit so "every word written" is representable
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ADDR_STEP  = (ADDRESS_WIDTH+1)'(4);

  state_t                  state;
  logic [ADDRESS_WIDTH:0]  word_addr;
  logic [1:0]              byte_idx;
  logic [DATA_WIDTH-1:0]   word_buf;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    accept;
  logic                    restart;

  assign accept  = byte_valid && byte_ready;
  assign restart = start && (state == IDLE || state == DONE || state == ERROR);

  // merge the incoming byte into its little-endian lane; unfilled lanes stay zero
  always_comb begin
    merged_word = word_buf | ({{(DATA_WIDTH-8){1'b0}}, byte_data} << {byte_idx, 3'b000});
  end

  // load sequencer: every output is registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_addr  <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            word_addr  <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            byte_ready <= 1'b1;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_addr == ADDR_LIMIT) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              err        <= 1'b1;
            end else if (byte_idx == 2'd3 || byte_last) begin
              wr_en    <= 1'b1;
              wr_data  <= merged_word;
              wr_addr  <= word_addr[ADDRESS_WIDTH-1:0];
              word_buf <= '0;
              byte_idx <= '0;
              if (byte_idx == 2'd3) begin
                word_addr <= word_addr + ADDR_STEP;
              end
              if (byte_last) begin
                state      <= FLUSH;
                byte_ready <= 1'b0;
              end
            end else begin
              word_buf <= merged_word;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        FLUSH: begin
          state   <= DONE;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_rst    <= 1'b1;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // running sum of written words, cleared whenever a new load begins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (restart) begin
      checksum <= '0;
    end else if (wr_en) begin
      checksum <= checksum + wr_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a per-cycle vector table on a default
// instance, plus hand sequences for mid-load reset and overflow on a small
// (ADDRESS_WIDTH=4) instance. Expected checksum follows LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;

  logic        aReady, aWrEn, aCpuRst, aDone, aErr;
  logic [8:0]  aWrAddr;
  logic [31:0] aWrData, aSum;

  logic        bReady, bWrEn, bCpuRst, bDone, bErr;
  logic [3:0]  bWrAddr;
  logic [31:0] bWrData, bSum;

  int checks = 0;
  int errors = 0;

  instr_mem_loader dutA (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(aReady),
    .wr_en(aWrEn), .wr_addr(aWrAddr), .wr_data(aWrData), .cpu_rst(aCpuRst),
    .done(aDone), .err(aErr), .checksum(aSum)
  );

  instr_mem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) dutB (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(bReady),
    .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData), .cpu_rst(bCpuRst),
    .done(bDone), .err(bErr), .checksum(bSum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstBefore;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        expReady;
    logic        expWr;
    logic [8:0]  expAddr;
    logic [31:0] expData;
    logic        expDone;
    logic        expCpuRst;
    logic [31:0] expSum;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] cs(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  function automatic vec_t mk(input logic rb, input logic st, input logic v,
                              input logic [7:0] d, input logic l, input logic rdy,
                              input logic we, input logic [8:0] ad, input logic [31:0] dat,
                              input logic dn, input logic cr, input logic [31:0] sm);
    vec_t t;
    t.rstBefore = rb; t.start = st; t.valid = v; t.data = d; t.last = l;
    t.expReady = rdy; t.expWr = we; t.expAddr = ad; t.expData = dat;
    t.expDone = dn; t.expCpuRst = cr; t.expSum = sm;
    return t;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic doReset();
    start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_ready"},  {31'b0, aReady},  32'h0);
    checkOutput({tag, "_wren"},   {31'b0, aWrEn},   32'h0);
    checkOutput({tag, "_wraddr"}, {23'b0, aWrAddr}, 32'h0);
    checkOutput({tag, "_wrdata"}, aWrData,          32'h0);
    checkOutput({tag, "_cpurst"}, {31'b0, aCpuRst}, 32'h1);
    checkOutput({tag, "_done"},   {31'b0, aDone},   32'h0);
    checkOutput({tag, "_err"},    {31'b0, aErr},    32'h0);
    checkOutput({tag, "_sum"},    aSum,             32'h0);
  endtask

  // one clock: drive inputs, take the edge, sample just after it
  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d, input logic l);
    start = st; byte_valid = v; byte_data = d; byte_last = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] expWord;
    logic [7:0]  byteVal;

    // reset + start, 13 00 50 00 with last on the 4th byte
    vecs.push_back(mk(1,1,0,8'h00,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h13,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h00,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h50,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h00,1, 0,1,9'h000,32'h00500013, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,0,9'h000,32'h0,        1,0, cs(32'h00500013)));
    // eight bytes 01..08 with valid gaps and an ignored start mid-load
    vecs.push_back(mk(1,1,0,8'h00,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h01,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h02,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,0,8'hEE,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h03,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h04,0, 1,1,9'h000,32'h04030201, 0,1, 32'h0));
    vecs.push_back(mk(0,1,1,8'h05,0, 1,0,9'h000,32'h0,        0,1, cs(32'h04030201)));
    vecs.push_back(mk(0,0,1,8'h06,0, 1,0,9'h000,32'h0,        0,1, cs(32'h04030201)));
    vecs.push_back(mk(0,0,0,8'hEE,0, 1,0,9'h000,32'h0,        0,1, cs(32'h04030201)));
    vecs.push_back(mk(0,0,1,8'h07,0, 1,0,9'h000,32'h0,        0,1, cs(32'h04030201)));
    vecs.push_back(mk(0,0,1,8'h08,1, 0,1,9'h004,32'h08070605, 0,1, cs(32'h04030201)));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,0,9'h000,32'h0,        1,0, cs(32'h0C0A0806)));
    vecs.push_back(mk(0,0,1,8'hFF,1, 0,0,9'h000,32'h0,        1,0, cs(32'h0C0A0806)));
    // AA BB with last on BB -> padded flush, then restart from DONE
    vecs.push_back(mk(1,1,0,8'h00,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'hAA,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'hBB,1, 0,1,9'h000,32'h0000BBAA, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,0,9'h000,32'h0,        1,0, cs(32'h0000BBAA)));
    vecs.push_back(mk(0,1,0,8'h00,0, 1,0,9'h000,32'h0,        0,1, 32'h0));
    vecs.push_back(mk(0,0,1,8'h11,1, 0,1,9'h000,32'h00000011, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,0,9'h000,32'h0,        1,0, cs(32'h00000011)));

    // reset values
    doReset();
    #1;
    checkResetA("reset");

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rstBefore) doReset();
      applyStimulus(vecs[r].start, vecs[r].valid, vecs[r].data, vecs[r].last);
      checkOutput($sformatf("row%0d_ready", r),  {31'b0, aReady},  {31'b0, vecs[r].expReady});
      checkOutput($sformatf("row%0d_wren", r),   {31'b0, aWrEn},   {31'b0, vecs[r].expWr});
      if (vecs[r].expWr) begin
        checkOutput($sformatf("row%0d_wraddr", r), {23'b0, aWrAddr}, {23'b0, vecs[r].expAddr});
        checkOutput($sformatf("row%0d_wrdata", r), aWrData,          vecs[r].expData);
      end
      checkOutput($sformatf("row%0d_done", r),   {31'b0, aDone},   {31'b0, vecs[r].expDone});
      checkOutput($sformatf("row%0d_cpurst", r), {31'b0, aCpuRst}, {31'b0, vecs[r].expCpuRst});
      checkOutput($sformatf("row%0d_err", r),    {31'b0, aErr},    32'h0);
      checkOutput($sformatf("row%0d_sum", r),    aSum,             vecs[r].expSum);
    end

    // mid-load reset: one full word written, two bytes of the next pending
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h04, 1'b0);
    checkOutput("midrst_firstwrite", {31'b0, aWrEn}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b0);
    byte_data = 8'h07;
    #2 rst = 1'b0;
    #1;
    checkResetA("midrst");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 8'h08, 1'b1);
      checkOutput($sformatf("midrst_hold%0d_wren", c), {31'b0, aWrEn}, 32'h0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b1);
    checkOutput("midrst_after_wren",  {31'b0, aWrEn},  32'h0);
    checkOutput("midrst_after_ready", {31'b0, aReady}, 32'h0);
    checkOutput("midrst_after_done",  {31'b0, aDone},  32'h0);

    // overflow on the 4-bit-address instance: 16 bytes fit, the 17th does not
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    expWord = 32'h0;
    for (int i = 0; i < 16; i++) begin
      byteVal = 8'(8'h40 + i);
      expWord[8*(i%4) +: 8] = byteVal;
      applyStimulus(1'b0, 1'b1, byteVal, 1'b0);
      if (i % 4 == 3) begin
        checkOutput($sformatf("ovf_w%0d_wren", i/4),   {31'b0, bWrEn},   32'h1);
        checkOutput($sformatf("ovf_w%0d_wraddr", i/4), {28'b0, bWrAddr}, 32'((i/4)*4));
        checkOutput($sformatf("ovf_w%0d_wrdata", i/4), bWrData,          expWord);
        expWord = 32'h0;
      end else begin
        checkOutput($sformatf("ovf_b%0d_wren", i), {31'b0, bWrEn}, 32'h0);
      end
    end
    checkOutput("ovf_full_ready", {31'b0, bReady}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0);
    checkOutput("ovf_err",    {31'b0, bErr},    32'h1);
    checkOutput("ovf_wren",   {31'b0, bWrEn},   32'h0);
    checkOutput("ovf_ready",  {31'b0, bReady},  32'h0);
    checkOutput("ovf_cpurst", {31'b0, bCpuRst}, 32'h1);
    checkOutput("ovf_done",   {31'b0, bDone},   32'h0);
    applyStimulus(1'b0, 1'b1, 8'h9A, 1'b1);
    checkOutput("ovf_hold_err",  {31'b0, bErr},  32'h1);
    checkOutput("ovf_hold_wren", {31'b0, bWrEn}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_restart_err",    {31'b0, bErr},    32'h0);
    checkOutput("ovf_restart_ready",  {31'b0, bReady},  32'h1);
    checkOutput("ovf_restart_cpurst", {31'b0, bCpuRst}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h21, 1'b1);
    checkOutput("ovf_restart_wren",   {31'b0, bWrEn},   32'h1);
    checkOutput("ovf_restart_wraddr", {28'b0, bWrAddr}, 32'h0);
    checkOutput("ovf_restart_wrdata", bWrData,          32'h00000021);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_restart_done",   {31'b0, bDone},   32'h1);
    checkOutput("ovf_restart_cpurst0",{31'b0, bCpuRst}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
